// File: rtl/dl_report_ctrl.sv
// Deadlock report controller: latches the lowest-index unit that flags a deadlock,
// confirms it over CONFIRM_CYCLES consecutive cycles, posts a report and clears tokens.
module dl_report_ctrl #(
    parameter int PROC_NUM       = 3,
    parameter int CONFIRM_CYCLES = 4,
    parameter int IDX_W          = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic                report_ack,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                report_valid,
    output logic [IDX_W-1:0]    report_idx,
    output logic [7:0]          report_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HOLD    = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(CONFIRM_CYCLES - 1);

    state_t              state_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [7:0]          cnt_reg;
    logic                detect_reg;
    logic [PROC_NUM-1:0] origin_reg;
    logic                token_clear_reg;
    logic                report_valid_reg;
    logic [IDX_W-1:0]    report_idx_reg;
    logic [7:0]          report_count_reg;

    // lower_any[k] is set when any unit below k is flagging, so only the lowest survives
    logic [PROC_NUM-1:0] lower_any;
    logic [PROC_NUM-1:0] first_onehot;
    logic [IDX_W-1:0]    first_idx;

    genvar gi;
    generate
        for (gi = 0; gi < PROC_NUM; gi++) begin : g_prio
            if (gi == 0) begin : g_first
                assign lower_any[gi] = 1'b0;
            end else begin : g_rest
                assign lower_any[gi] = lower_any[gi-1] | dl_in_vec[gi-1];
            end
            assign first_onehot[gi] = dl_in_vec[gi] & ~lower_any[gi];
        end
    endgenerate

    always_comb begin
        first_idx = '0;
        for (int i = 0; i < PROC_NUM; i++) begin
            if (first_onehot[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

    // origin_reg is one-hot on the latched unit, so masking isolates its flag
    logic       tracked_bit;
    logic [7:0] count_inc;

    assign tracked_bit = |(dl_in_vec & origin_reg);
    assign count_inc   = (report_count_reg == 8'hFF) ? report_count_reg : report_count_reg + 8'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            cnt_reg          <= '0;
            detect_reg       <= 1'b0;
            origin_reg       <= '0;
            token_clear_reg  <= 1'b0;
            report_valid_reg <= 1'b0;
            report_idx_reg   <= '0;
            report_count_reg <= '0;
        end else begin
            report_valid_reg <= 1'b0;
            token_clear_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|dl_in_vec) begin
                        idx_reg    <= first_idx;
                        origin_reg <= first_onehot;
                        detect_reg <= 1'b1;
                        cnt_reg    <= 8'd1;
                        if (CONFIRM_CYCLES == 1) begin
                            state_reg        <= HOLD;
                            report_valid_reg <= 1'b1;
                            report_idx_reg   <= first_idx;
                            report_count_reg <= count_inc;
                        end else begin
                            state_reg <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (tracked_bit) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_reg        <= HOLD;
                            report_valid_reg <= 1'b1;
                            report_idx_reg   <= idx_reg;
                            report_count_reg <= count_inc;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end else begin
                        state_reg       <= CLEAR;
                        token_clear_reg <= 1'b1;
                        detect_reg      <= 1'b0;
                        origin_reg      <= '0;
                    end
                end
                HOLD: begin
                    if (report_ack) begin
                        state_reg       <= CLEAR;
                        token_clear_reg <= 1'b1;
                        detect_reg      <= 1'b0;
                        origin_reg      <= '0;
                    end
                end
                CLEAR: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign dl_detect_out = detect_reg;
    assign origin        = origin_reg;
    assign token_clear   = token_clear_reg;
    assign report_valid  = report_valid_reg;
    assign report_idx    = report_idx_reg;
    assign report_count  = report_count_reg;

endmodule

// File: tb/tb_dl_report_ctrl.sv
// Bench for dl_report_ctrl: directed scenarios plus random traffic against a
// transaction-level model of detection, confirmation, report and clear.
module tb_dl_report_ctrl;

    localparam int CC = 4;

    logic       clock;
    logic       reset;
    logic [2:0] vec;
    logic       ack;
    logic       detect;
    logic [2:0] origin;
    logic       tc;
    logic       rv;
    logic [1:0] ridx;
    logic [7:0] rcount;

    logic       vec1_bit;
    logic [2:0] vec1;
    logic       ack1;
    logic       detect1;
    logic [2:0] origin1;
    logic       tc1;
    logic       rv1;
    logic [1:0] ridx1;
    logic [7:0] rcount1;

    int n_checks;
    int n_fail;

    dl_report_ctrl #(.PROC_NUM(3), .CONFIRM_CYCLES(CC), .IDX_W(2)) dut (
        .clock(clock), .reset(reset), .dl_in_vec(vec), .report_ack(ack),
        .dl_detect_out(detect), .origin(origin), .token_clear(tc),
        .report_valid(rv), .report_idx(ridx), .report_count(rcount)
    );

    dl_report_ctrl #(.PROC_NUM(3), .CONFIRM_CYCLES(1), .IDX_W(2)) dut1 (
        .clock(clock), .reset(reset), .dl_in_vec(vec1), .report_ack(ack1),
        .dl_detect_out(detect1), .origin(origin1), .token_clear(tc1),
        .report_valid(rv1), .report_idx(ridx1), .report_count(rcount1)
    );

    assign vec1 = {2'b00, vec1_bit};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: a trace is either absent, being confirmed (age = edges seen high),
    // reported and waiting for ack, or in its one-cycle clear.
    bit   m_active;
    bit   m_reported;
    bit   m_clear;
    int   m_idx;
    int   m_age;
    int   m_ridx;
    int   m_count;
    bit   m_rv;
    bit   m_tc;

    task automatic model_reset();
        m_active = 0; m_reported = 0; m_clear = 0;
        m_idx = 0; m_age = 0; m_ridx = 0; m_count = 0;
        m_rv = 0; m_tc = 0;
    endtask

    task automatic model_report();
        m_reported = 1;
        m_rv = 1;
        m_ridx = m_idx;
        if (m_count < 255) m_count++;
    endtask

    task automatic model_clear();
        m_active = 0;
        m_reported = 0;
        m_clear = 1;
        m_tc = 1;
    endtask

    task automatic model_step(input logic [2:0] v, input logic a);
        m_rv = 0;
        m_tc = 0;
        if (m_clear) begin
            m_clear = 0;
        end else if (!m_active) begin
            if (v != 3'b000) begin
                for (int i = 2; i >= 0; i--) if (v[i]) m_idx = i;
                m_active = 1;
                m_age = 1;
                if (m_age >= CC) model_report();
            end
        end else if (!m_reported) begin
            if (v[m_idx]) begin
                m_age++;
                if (m_age >= CC) model_report();
            end else begin
                model_clear();
            end
        end else if (a) begin
            model_clear();
        end
    endtask

    function automatic logic [2:0] m_origin();
        logic [2:0] o;
        o = 3'b000;
        if (m_active) o[m_idx] = 1'b1;
        return o;
    endfunction

    task automatic cycle();
        @(posedge clock);
        model_step(vec, ack);
        #1;
        if (m_rv) $display("report idx=%0d count=%0d", m_ridx, m_count);
    endtask

    task automatic test_reset();
        reset = 1'b0; vec = 3'b111; ack = 1'b1; vec1_bit = 1'b1; ack1 = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({detect, origin, tc, rv, ridx, rcount} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got det=%b org=%b tc=%b rv=%b idx=%0d cnt=%0d, want all 0",
                     detect, origin, tc, rv, ridx, rcount);
        end
        n_checks++;
        if ({detect1, origin1, tc1, rv1, ridx1, rcount1} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_cc1: got det=%b rv=%b cnt=%0d, want all 0", detect1, rv1, rcount1);
        end
        vec = 3'b000; ack = 1'b0; vec1_bit = 1'b0; ack1 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_confirmed_report();
        vec = 3'b010;
        cycle();
        n_checks++;
        if (origin !== 3'b010 || detect !== 1'b1) begin
            n_fail++;
            $display("FAIL confirm_capture: got origin=%b det=%b, want 010/1", origin, detect);
        end
        for (int e = 1; e <= 2; e++) begin
            cycle();
            n_checks++;
            if (rv !== 1'b0) begin
                n_fail++;
                $display("FAIL confirm_early_rv edge%0d: got %b want 0", e, rv);
            end
        end
        cycle();
        n_checks++;
        if (rv !== 1'b1 || ridx !== 2'd1 || rcount !== 8'd1) begin
            n_fail++;
            $display("FAIL confirm_report: got rv=%b idx=%0d cnt=%0d, want 1/1/1", rv, ridx, rcount);
        end
        vec = 3'b000;
        for (int e = 4; e <= 5; e++) begin
            cycle();
            n_checks++;
            if (rv !== 1'b0 || detect !== 1'b1 || origin !== 3'b010 || ridx !== 2'd1) begin
                n_fail++;
                $display("FAIL hold_stable edge%0d: got rv=%b det=%b org=%b idx=%0d", e, rv, detect, origin, ridx);
            end
        end
        ack = 1'b1;
        cycle();
        n_checks++;
        if (tc !== 1'b1 || detect !== 1'b0 || origin !== 3'b000) begin
            n_fail++;
            $display("FAIL ack_clear: got tc=%b det=%b org=%b, want 1/0/000", tc, detect, origin);
        end
        ack = 1'b0;
        cycle();
        n_checks++;
        if (tc !== 1'b0 || rcount !== 8'd1) begin
            n_fail++;
            $display("FAIL clear_one_cycle: got tc=%b cnt=%0d, want 0/1", tc, rcount);
        end
    endtask

    task automatic test_false_alarm();
        vec = 3'b100;
        cycle();
        cycle();
        vec = 3'b000;
        cycle();
        n_checks++;
        if (tc !== 1'b1 || rv !== 1'b0 || detect !== 1'b0 || rcount !== 8'd1) begin
            n_fail++;
            $display("FAIL false_alarm: got tc=%b rv=%b det=%b cnt=%0d, want 1/0/0/1", tc, rv, detect, rcount);
        end
        cycle();
        n_checks++;
        if (tc !== 1'b0 || rv !== 1'b0) begin
            n_fail++;
            $display("FAIL false_alarm_after: got tc=%b rv=%b, want 0/0", tc, rv);
        end
    endtask

    task automatic test_priority();
        vec = 3'b101;
        cycle();
        n_checks++;
        if (origin !== 3'b001) begin
            n_fail++;
            $display("FAIL priority_origin: got %b want 001", origin);
        end
        vec = 3'b111;
        cycle();
        n_checks++;
        if (origin !== 3'b001) begin
            n_fail++;
            $display("FAIL priority_hold_origin: got %b want 001", origin);
        end
        vec = 3'b100;
        cycle();
        n_checks++;
        if (tc !== 1'b1 || origin !== 3'b000) begin
            n_fail++;
            $display("FAIL priority_false_alarm: got tc=%b org=%b, want 1/000", tc, origin);
        end
        cycle();
        n_checks++;
        if (detect !== 1'b0 || origin !== 3'b000) begin
            n_fail++;
            $display("FAIL priority_no_capture_in_clear: got det=%b org=%b, want 0/000", detect, origin);
        end
        cycle();
        n_checks++;
        if (detect !== 1'b1 || origin !== 3'b100) begin
            n_fail++;
            $display("FAIL priority_recapture: got det=%b org=%b, want 1/100", detect, origin);
        end
        vec = 3'b000;
        cycle();
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) vec = 3'($urandom_range(7));
            ack = ($urandom_range(2) == 0);
            cycle();
            n_checks++;
            if (detect !== m_active || origin !== m_origin() || tc !== m_tc || rv !== m_rv) begin
                n_fail++;
                $display("FAIL random_ctrl cyc%0d: got det=%b org=%b tc=%b rv=%b, want %b/%b/%b/%b",
                         c, detect, origin, tc, rv, m_active, m_origin(), m_tc, m_rv);
            end
            n_checks++;
            if (rcount !== 8'(m_count) || (m_reported && ridx !== 2'(m_ridx))) begin
                n_fail++;
                $display("FAIL random_report cyc%0d: got idx=%0d cnt=%0d, want %0d/%0d",
                         c, ridx, rcount, m_ridx, m_count);
            end
        end
        vec = 3'b000; ack = 1'b1;
        repeat (3) cycle();
        ack = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic test_saturation();
        vec = 3'b001; ack = 1'b1;
        for (int c = 0; c < 6 * 260; c++) begin
            cycle();
            if (m_rv) begin
                n_checks++;
                if (rv !== 1'b1 || rcount !== 8'(m_count)) begin
                    n_fail++;
                    $display("FAIL sat_step cyc%0d: got rv=%b cnt=%0d, want 1/%0d", c, rv, rcount, m_count);
                end
            end
        end
        n_checks++;
        if (rcount !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: got %0d want 255", rcount);
        end
        vec = 3'b000;
        repeat (4) cycle();
        ack = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        vec = 3'b001;
        repeat (CC) cycle();
        n_checks++;
        if (rv !== 1'b1 || detect !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_hold: got rv=%b det=%b, want 1/1", rv, detect);
        end
        vec = 3'b000;
        cycle();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({detect, origin, tc, rv, ridx, rcount} !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got det=%b org=%b tc=%b rv=%b cnt=%0d, want all 0",
                     detect, origin, tc, rv, rcount);
        end
        @(posedge clock);
        #3 reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (tc !== 1'b0 || detect !== 1'b0 || rcount !== 8'd0) begin
            n_fail++;
            $display("FAIL after_reset: got tc=%b det=%b cnt=%0d, want 0/0/0", tc, detect, rcount);
        end
        vec = 3'b010;
        cycle();
        n_checks++;
        if (origin !== 3'b010 || detect !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_capture: got org=%b det=%b, want 010/1", origin, detect);
        end
        repeat (CC - 1) cycle();
        n_checks++;
        if (rv !== 1'b1 || rcount !== 8'd1 || ridx !== 2'd1) begin
            n_fail++;
            $display("FAIL post_reset_report: got rv=%b cnt=%0d idx=%0d, want 1/1/1", rv, rcount, ridx);
        end
        vec = 3'b000; ack = 1'b1;
        cycle();
        ack = 1'b0;
        cycle();
    endtask

    task automatic test_cc1();
        vec1_bit = 1'b1;
        cycle();
        n_checks++;
        if (detect1 !== 1'b1 || rv1 !== 1'b1 || origin1 !== 3'b001 || ridx1 !== 2'd0 || rcount1 !== 8'd1) begin
            n_fail++;
            $display("FAIL cc1_same_edge: got det=%b rv=%b org=%b idx=%0d cnt=%0d, want 1/1/001/0/1",
                     detect1, rv1, origin1, ridx1, rcount1);
        end
        vec1_bit = 1'b0;
        cycle();
        n_checks++;
        if (rv1 !== 1'b0 || detect1 !== 1'b1) begin
            n_fail++;
            $display("FAIL cc1_hold: got rv=%b det=%b, want 0/1", rv1, detect1);
        end
        ack1 = 1'b1;
        cycle();
        n_checks++;
        if (tc1 !== 1'b1 || detect1 !== 1'b0) begin
            n_fail++;
            $display("FAIL cc1_clear: got tc=%b det=%b, want 1/0", tc1, detect1);
        end
        ack1 = 1'b0;
        cycle();
        n_checks++;
        if (tc1 !== 1'b0) begin
            n_fail++;
            $display("FAIL cc1_clear_pulse: got tc=%b want 0", tc1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_confirmed_report();
        test_false_alarm();
        test_priority();
        test_random();
        test_saturation();
        test_reset_mid_hold();
        test_cc1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_report_ctrl.md
DL_REPORT_CTRL -- requirements
Module: dl_report_ctrl

Interface
REQ-001 The block SHALL have parameter PROC_NUM, default 3: number of deadlock detect units feeding the block (range 1..64).
REQ-002 The block SHALL have parameter CONFIRM_CYCLES, default 4: consecutive cycles a detection must persist before it is reported (range 1..255).
REQ-003 The block SHALL have parameter IDX_W, default 2: width of the process index, equal to max(1, clog2(PROC_NUM)).
REQ-004 Port clock SHALL be: clock, input, 1, rising-edge clock.
REQ-005 Port reset SHALL be: reset, input, 1, asynchronous, active-low.
REQ-006 Port dl_in_vec SHALL be: input, PROC_NUM, per-unit deadlock-detected flags.
REQ-007 Port report_ack SHALL be: input, 1, bench/monitor acknowledge of a posted report.
REQ-008 Port dl_detect_out SHALL be: output, 1, global freeze to all detect units.
REQ-009 Port origin SHALL be: output, PROC_NUM, one-hot marker of the unit that started the trace.
REQ-010 Port token_clear SHALL be: output, 1, single-cycle pulse that clears all detect-unit tokens.
REQ-011 Port report_valid SHALL be: output, 1, single-cycle pulse marking a confirmed deadlock.
REQ-012 Port report_idx SHALL be: output, IDX_W, index of the confirmed unit, valid while in HOLD.
REQ-013 Port report_count SHALL be: output, 8, number of confirmed reports, saturating at 255.

Function
REQ-014 The block SHALL implement FSM states IDLE, CONFIRM, HOLD and CLEAR; all outputs SHALL be registered.
REQ-015 In IDLE with dl_in_vec != 0, the block SHALL select the lowest set index i, latch i, set origin = onehot(i), set dl_detect_out = 1, and load cnt = 1 on the same edge.
REQ-016 From IDLE, the block SHALL go to HOLD when CONFIRM_CYCLES == 1 (with the report actions of REQ-018), else to CONFIRM.
REQ-017 In CONFIRM, the block SHALL sample only dl_in_vec[i]; all other bits SHALL be ignored.
REQ-018 In CONFIRM with dl_in_vec[i] == 1 and cnt == CONFIRM_CYCLES-1, the block SHALL go to HOLD, pulse report_valid for one cycle, drive report_idx = i, and increment report_count unless it is already 255.
REQ-019 In CONFIRM with dl_in_vec[i] == 1 and cnt < CONFIRM_CYCLES-1, the block SHALL increment cnt and stay in CONFIRM.
REQ-020 In CONFIRM with dl_in_vec[i] == 0 (false alarm), the block SHALL go to CLEAR with no report and no count change.
REQ-021 In HOLD, dl_detect_out, origin and report_idx SHALL stay constant and dl_in_vec SHALL be ignored.
REQ-022 On report_ack == 1 in HOLD, the block SHALL go to CLEAR; report_ack in any other state SHALL be ignored.
REQ-023 Entering CLEAR, the block SHALL set token_clear = 1, dl_detect_out = 0 and origin = 0.
REQ-024 CLEAR SHALL last exactly one cycle, then go to IDLE; dl_in_vec SHALL be ignored during CLEAR, and re-arming SHALL occur no earlier than the first IDLE cycle.
REQ-025 Latency: dl_in_vec[i] sampled high at edge t SHALL give dl_detect_out high after edge t, and report_valid high after edge t+CONFIRM_CYCLES-1.
REQ-026 When several bits rise in the same cycle, the lowest index SHALL win; later rises of other bits SHALL not change origin.
REQ-027 In all states other than those entering HOLD and CLEAR, report_valid and token_clear SHALL be 0.

Reset
REQ-028 While reset == 0, state SHALL be IDLE and all outputs and cnt SHALL be 0, independent of clock.
REQ-029 Reset asserted mid-CONFIRM or mid-HOLD SHALL abort immediately with no token_clear pulse; report_count SHALL return to 0.
REQ-030 The first edge after reset release SHALL evaluate dl_in_vec as in IDLE.

Verification (PROC_NUM=3, CONFIRM_CYCLES=4 unless stated)
REQ-031 Confirmed report: dl_in_vec=3'b010 held from edge 0 -> origin=3'b010 and dl_detect_out=1 after edge 0; report_valid=1 for one cycle after edge 3; report_idx=1; report_count=1; report_ack at edge 6 -> token_clear=1 for one cycle after edge 6; IDLE after edge 7.
REQ-032 False alarm: dl_in_vec=3'b100 at edges 0-1, 0 at edge 2 -> token_clear pulse after edge 2; report_valid never 1; report_count unchanged.
REQ-033 Priority: dl_in_vec=3'b101 at edge 0 -> origin=3'b001; bit 0 deasserted with bit 2 still high -> false alarm; re-capture of bit 2 no earlier than the IDLE cycle after CLEAR.
REQ-034 Saturation: 256 confirmed report/ack cycles -> report_count=255, not 0.
REQ-035 Reset mid-HOLD: reset low for 1 cycle during HOLD -> all outputs 0 immediately, no token_clear; normal operation after release.
REQ-036 CONFIRM_CYCLES=1 instance: single-cycle dl_in_vec=3'b001 -> dl_detect_out and report_valid both 1 after the same edge.
